shift_sequencer: RTL and testbench

Multi-cycle shift controller for the ALU shift path. It accepts one SLL/SRL/SRA request and sequences a reusable shift-by-two/shift-by-one step across cycles until the shift amount is consumed, then pulses `done_o`. It sits beside the ALU and lets the datapath share one small shift stage instead of a full 32-bit barrel shifter.

---
 rtl/shift_pkg.sv | 21 ++
 rtl/shift_step.sv | 35 +++
 rtl/shift_sequencer.sv | 100 ++++++++++
 tb/tb_shift_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer.
// Provides the shift op encoding, the FSM state encoding and default widths.
package shift_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_SHAMT_W = 5;

  // Shift operation encoding as presented on op_i
  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_RSV = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage : shift_pkg

// File: rtl/shift_step.sv
// Single reusable shift stage: shifts data by one or two bit positions.
// Ports:
//   data    in  WIDTH  value to shift
//   op      in  2      SLL / SRL / SRA (reserved passes data through)
//   by2     in  1      1 = shift by two, 0 = shift by one
//   shifted out WIDTH  combinational result
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       op,
  input  logic             by2,
  output logic [WIDTH-1:0] shifted
);

  logic       fill;
  logic [1:0] fill2;

  // Right shifts fill with zero or the sign bit; SRA fills both vacated bits
  assign fill  = (op == SH_SRA) ? data[WIDTH-1] : 1'b0;
  assign fill2 = {fill, fill};

  always_comb begin
    shifted = data;
    unique case (op)
      SH_SLL: shifted = by2 ? {data[WIDTH-3:0], 2'b00} : {data[WIDTH-2:0], 1'b0};
      SH_SRL,
      SH_SRA: shifted = by2 ? {fill2, data[WIDTH-1:2]} : {fill, data[WIDTH-1:1]};
      default: shifted = data;
    endcase
  end

endmodule : shift_step

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: sequences a shared by-2/by-1 shift stage until
// the requested shift amount is consumed, then pulses done_o for one cycle.
// Ports:
//   clk_i     in  1        clock, rising edge
//   rst_i     in  1        asynchronous active-low reset
//   start_i   in  1        request, sampled only while idle
//   op_i      in  2        00 SLL, 01 SRL, 10 SRA, 11 reserved (pass-through)
//   data_i    in  WIDTH    operand captured with start
//   shamt_i   in  SHAMT_W  shift amount captured with start
//   busy_o    out 1        high while shifting and in the done cycle
//   done_o    out 1        one-cycle completion pulse
//   result_o  out WIDTH    working / result register
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   result_o
);

  state_t             state;
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] rem;
  logic               by2;
  logic [SHAMT_W-1:0] rem_next;
  logic [WIDTH-1:0]   step_out;

  // Take two bits per step while at least two remain, otherwise the last one
  assign by2      = (rem >= SHAMT_W'(2));
  assign rem_next = by2 ? (rem - SHAMT_W'(2)) : '0;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data    (result_o),
    .op      (op_q),
    .by2     (by2),
    .shifted (step_out)
  );

  // Sequencer FSM with registered status outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      op_q     <= SH_SLL;
      rem      <= '0;
      result_o <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          busy_o <= 1'b0;
          done_o <= 1'b0;
          if (start_i) begin
            result_o <= data_i;
            op_q     <= op_i;
            rem      <= shamt_i;
            busy_o   <= 1'b1;
            // Nothing to shift: report the operand unchanged next cycle
            if ((shamt_i == '0) || (op_i == SH_RSV)) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          result_o <= step_out;
          rem      <= rem_next;
          if (rem_next == '0) begin
            state  <= ST_DONE;
            done_o <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule : shift_sequencer

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
module tb_shift_sequencer;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] data_i;
  logic [4:0]  shamt_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int total;
  int bad;

  shift_sequencer #(
    .WIDTH   (32),
    .SHAMT_W (5)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .data_i   (data_i),
    .shamt_i  (shamt_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Directed vectors: op, data, shamt, expected result, expected done cycle
  localparam int NV = 9;
  logic [1:0]  v_op   [NV] = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b11,
                               2'b10, 2'b01, 2'b10, 2'b00};
  logic [31:0] v_data [NV] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000,
                               32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8000_0000,
                               32'h8000_0000, 32'h4000_0000, 32'hFFFF_FFFF};
  logic [4:0]  v_sh   [NV] = '{5'd5, 5'd31, 5'd31, 5'd0, 5'd7, 5'd2, 5'd1, 5'd3, 5'd31};
  logic [31:0] v_exp  [NV] = '{32'h0000_0020, 32'hFFFF_FFFF, 32'h0000_0001,
                               32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hE000_0000,
                               32'h4000_0000, 32'h0800_0000, 32'h8000_0000};
  int          v_cyc  [NV] = '{4, 17, 17, 1, 1, 2, 2, 3, 17};

  // Present a request across one rising edge; returns at the negedge of cycle 1
  task automatic issue(input logic [1:0] op, input logic [31:0] data, input logic [4:0] sh);
    @(negedge clk_i);
    start_i = 1'b1;
    op_i    = op;
    data_i  = data;
    shamt_i = sh;
    @(negedge clk_i);
    start_i = 1'b0;
    data_i  = 32'h0;
    shamt_i = 5'd0;
  endtask

  task automatic test_reset();
    rst_i   = 1'b0;
    start_i = 1'b0;
    op_i    = 2'b00;
    data_i  = 32'h0;
    shamt_i = 5'd0;
    repeat (2) @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b result=%h, want 0 0 00000000",
               busy_o, done_o, result_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_vectors();
    for (int v = 0; v < NV; v++) begin
      issue(v_op[v], v_data[v], v_sh[v]);
      for (int c = 1; c <= v_cyc[v] + 2; c++) begin
        if (c > 1) @(negedge clk_i);
        total++;
        if (done_o !== (c == v_cyc[v])) begin
          bad++;
          $display("FAIL vec%0d_done cycle %0d: got %b want %b", v, c, done_o, (c == v_cyc[v]));
        end
        total++;
        if (busy_o !== (c <= v_cyc[v])) begin
          bad++;
          $display("FAIL vec%0d_busy cycle %0d: got %b want %b", v, c, busy_o, (c <= v_cyc[v]));
        end
        if (c >= v_cyc[v]) begin
          total++;
          if (result_o !== v_exp[v]) begin
            bad++;
            $display("FAIL vec%0d_result cycle %0d: got %h want %h", v, c, result_o, v_exp[v]);
          end
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    issue(2'b00, 32'h1, 5'd4);
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk_i);
      // Second request raised while shifting; sampled in cycle 2
      if (c == 2) begin
        start_i = 1'b1;
        data_i  = 32'hFF;
        shamt_i = 5'd1;
      end else begin
        start_i = 1'b0;
        data_i  = 32'h0;
        shamt_i = 5'd0;
      end
      total++;
      if (done_o !== (c == 3)) begin
        bad++;
        $display("FAIL ignore_done cycle %0d: got %b want %b", c, done_o, (c == 3));
      end
      if (c >= 3) begin
        total++;
        if (result_o !== 32'h10) begin
          bad++;
          $display("FAIL ignore_result cycle %0d: got %h want 00000010", c, result_o);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    issue(2'b01, 32'hF000_0000, 5'd8);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0) begin
      bad++;
      $display("FAIL midreset_outputs: busy=%b done=%b result=%h, want 0 0 00000000",
               busy_o, done_o, result_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL midreset_idle: busy=%b done=%b want 0 0", busy_o, done_o);
    end
    issue(2'b01, 32'hF000_0000, 5'd4);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk_i);
      total++;
      if (done_o !== (c == 3)) begin
        bad++;
        $display("FAIL postreset_done cycle %0d: got %b want %b", c, done_o, (c == 3));
      end
    end
    total++;
    if (result_o !== 32'h0F00_0000) begin
      bad++;
      $display("FAIL postreset_result: got %h want 0f000000", result_o);
    end
  endtask

  task automatic test_back_to_back();
    issue(2'b00, 32'h3, 5'd2);
    @(negedge clk_i);
    total++;
    if (done_o !== 1'b1 || result_o !== 32'hC) begin
      bad++;
      $display("FAIL b2b_first: done=%b result=%h want 1 0000000c", done_o, result_o);
    end
    // Start raised in the IDLE cycle directly after DONE
    issue(2'b10, 32'h8000_0000, 5'd3);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk_i);
      total++;
      if (done_o !== (c == 3)) begin
        bad++;
        $display("FAIL b2b_done cycle %0d: got %b want %b", c, done_o, (c == 3));
      end
      total++;
      if (busy_o !== (c <= 3)) begin
        bad++;
        $display("FAIL b2b_busy cycle %0d: got %b want %b", c, busy_o, (c <= 3));
      end
    end
    total++;
    if (result_o !== 32'hF000_0000) begin
      bad++;
      $display("FAIL b2b_second_result: got %h want f0000000", result_o);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_vectors();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_shift_sequencer
